// File: rtl/decode_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_if
//  Description : Fetch-side and EX-side signal bundle of the swt16 DC stage.
//                master = upstream driver / observer, slave = decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface decode_if #(
    parameter int PC_WIDTH    = 12,
    parameter int INSTR_WIDTH = 16
);
    logic [INSTR_WIDTH-1:0] in_instr;
    logic [PC_WIDTH-1:0]    in_pc;
    logic                   in_flush;
    logic                   out_stall_fe;
    logic [3:0]             out_rf_addr1;
    logic [3:0]             out_rf_addr2;
    logic                   out_valid;
    logic [3:0]             out_op;
    logic [3:0]             out_rd;
    logic [3:0]             out_rs1;
    logic [3:0]             out_rs2;
    logic [15:0]            out_imm;
    logic [PC_WIDTH-1:0]    out_pc;

    modport master (
        output in_instr, in_pc, in_flush,
        input  out_stall_fe, out_rf_addr1, out_rf_addr2, out_valid,
               out_op, out_rd, out_rs1, out_rs2, out_imm, out_pc
    );

    modport slave (
        input  in_instr, in_pc, in_flush,
        output out_stall_fe, out_rf_addr1, out_rf_addr2, out_valid,
               out_op, out_rd, out_rs1, out_rs2, out_imm, out_pc
    );
endinterface
`default_nettype wire

// File: rtl/decode.sv
`default_nettype none
// ============================================================================
//  Module      : decode
//  Description : swt16 DC stage. Splits 16-bit words into fields, assembles
//                two-word long-immediate ops, detects load-use hazards and
//                registers the result into the DC->EX pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode #(
    parameter int PC_WIDTH    = 12,
    parameter int INSTR_WIDTH = 16
) (
    input  wire logic clock,
    input  wire logic reset,
    decode_if.slave   bus
);

    typedef enum logic [0:0] {
        S_W0 = 1'b0,    // expecting a first word
        S_W1 = 1'b1     // expecting the imm16 word of a long op
    } state_t;

    localparam logic [3:0] c_OP_LOAD = 4'h4;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   r_valid;
    logic [3:0]             r_op;
    logic [3:0]             r_rd;
    logic [3:0]             r_rs1;
    logic [3:0]             r_rs2;
    logic [15:0]            r_imm;
    logic [PC_WIDTH-1:0]    r_pc;

    logic                   w_valid_nxt;
    logic [3:0]             w_op_nxt;
    logic [3:0]             w_rd_nxt;
    logic [3:0]             w_rs1_nxt;
    logic [3:0]             w_rs2_nxt;
    logic [15:0]            w_imm_nxt;
    logic [PC_WIDTH-1:0]    w_pc_nxt;

    // First word of a pending long op, held while its immediate arrives
    logic [3:0]             r_hold_op;
    logic [3:0]             r_hold_rd;
    logic [3:0]             r_hold_rs1;
    logic [3:0]             r_hold_rs2;
    logic [PC_WIDTH-1:0]    r_hold_pc;

    logic [3:0]             w_hold_op_nxt;
    logic [3:0]             w_hold_rd_nxt;
    logic [3:0]             w_hold_rs1_nxt;
    logic [3:0]             w_hold_rs2_nxt;
    logic [PC_WIDTH-1:0]    w_hold_pc_nxt;

    logic [INSTR_WIDTH-1:0] w_instr;
    logic                   w_is_nop;
    logic                   w_is_long;
    logic                   w_hazard;

    assign w_instr   = bus.in_instr;
    assign w_is_nop  = (w_instr == '0);
    assign w_is_long = (w_instr[15:14] == 2'b10);

    // A LOAD in EX whose destination feeds the word now in DC must wait a cycle;
    // the immediate word of a long op carries no register operands.
    assign w_hazard = (r_state == S_W0) && r_valid && (r_op == c_OP_LOAD) && !w_is_nop
                   && ((r_rd == w_instr[7:4]) || (r_rd == w_instr[3:0]));

    // A flush overrides the stall: the stalled word is being squashed anyway
    assign bus.out_stall_fe = w_hazard & ~bus.in_flush;
    assign bus.out_rf_addr1 = w_instr[7:4];
    assign bus.out_rf_addr2 = w_instr[3:0];

    assign bus.out_valid = r_valid;
    assign bus.out_op    = r_op;
    assign bus.out_rd    = r_rd;
    assign bus.out_rs1   = r_rs1;
    assign bus.out_rs2   = r_rs2;
    assign bus.out_imm   = r_imm;
    assign bus.out_pc    = r_pc;

    // Next-state and next DC->EX contents; defaults describe a bubble
    always_comb begin
        w_state_nxt    = r_state;
        w_valid_nxt    = 1'b0;
        w_op_nxt       = '0;
        w_rd_nxt       = '0;
        w_rs1_nxt      = '0;
        w_rs2_nxt      = '0;
        w_imm_nxt      = '0;
        w_pc_nxt       = '0;
        w_hold_op_nxt  = r_hold_op;
        w_hold_rd_nxt  = r_hold_rd;
        w_hold_rs1_nxt = r_hold_rs1;
        w_hold_rs2_nxt = r_hold_rs2;
        w_hold_pc_nxt  = r_hold_pc;

        if (bus.in_flush) begin
            w_state_nxt = S_W0;
        end else if (r_state == S_W1) begin
            w_valid_nxt = 1'b1;
            w_op_nxt    = r_hold_op;
            w_rd_nxt    = r_hold_rd;
            w_rs1_nxt   = r_hold_rs1;
            w_rs2_nxt   = r_hold_rs2;
            w_imm_nxt   = w_instr[15:0];
            w_pc_nxt    = r_hold_pc;
            w_state_nxt = S_W0;
        end else if (w_hazard) begin
            w_state_nxt = S_W0;
        end else if (w_is_long) begin
            w_hold_op_nxt  = w_instr[15:12];
            w_hold_rd_nxt  = w_instr[11:8];
            w_hold_rs1_nxt = w_instr[7:4];
            w_hold_rs2_nxt = w_instr[3:0];
            w_hold_pc_nxt  = bus.in_pc;
            w_state_nxt    = S_W1;
        end else begin
            w_valid_nxt = !w_is_nop;
            w_op_nxt    = w_instr[15:12];
            w_rd_nxt    = w_instr[11:8];
            w_rs1_nxt   = w_instr[7:4];
            w_rs2_nxt   = w_instr[3:0];
            w_imm_nxt   = {{12{w_instr[3]}}, w_instr[3:0]};
            w_pc_nxt    = bus.in_pc;
        end
    end

    // State, DC->EX pipeline register and long-op holding registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_W0;
            r_valid    <= 1'b0;
            r_op       <= '0;
            r_rd       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
            r_hold_op  <= '0;
            r_hold_rd  <= '0;
            r_hold_rs1 <= '0;
            r_hold_rs2 <= '0;
            r_hold_pc  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_valid    <= w_valid_nxt;
            r_op       <= w_op_nxt;
            r_rd       <= w_rd_nxt;
            r_rs1      <= w_rs1_nxt;
            r_rs2      <= w_rs2_nxt;
            r_imm      <= w_imm_nxt;
            r_pc       <= w_pc_nxt;
            r_hold_op  <= w_hold_op_nxt;
            r_hold_rd  <= w_hold_rd_nxt;
            r_hold_rs1 <= w_hold_rs1_nxt;
            r_hold_rs2 <= w_hold_rs2_nxt;
            r_hold_pc  <= w_hold_pc_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode
//  Description : Self-checking bench for the swt16 DC stage: directed
//                scenarios plus randomized words against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode;
    localparam int PC_WIDTH = 12;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    decode_if #(.PC_WIDTH(PC_WIDTH)) bus ();

    decode #(.PC_WIDTH(PC_WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        valid;
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [15:0] imm;
        logic [11:0] pc;
    } dc_t;

    // Observed DC->EX register contents
    function automatic dc_t obs();
        dc_t o;
        o = {bus.out_valid, bus.out_op, bus.out_rd, bus.out_rs1, bus.out_rs2,
             bus.out_imm, bus.out_pc};
        return o;
    endfunction

    // Expected record built from an instruction word's fields
    function automatic dc_t mk(logic v, logic [15:0] w, logic [15:0] imm, logic [11:0] pc);
        dc_t e;
        e = {v, w[15:12], w[11:8], w[7:4], w[3:0], imm, pc};
        return e;
    endfunction

    // Low nibble as a signed 4-bit value widened to 16 bits
    function automatic logic [15:0] sext(logic [15:0] w);
        int s;
        s = (w[3] ? int'(w[3:0]) - 16 : int'(w[3:0]));
        return 16'(s);
    endfunction

    task automatic drive(logic [15:0] w, logic [11:0] pc, logic fl);
        bus.in_instr = w;
        bus.in_pc    = pc;
        bus.in_flush = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(16'h1234, 12'h010, 1'b0);
        tick();
        vectors++;
        if (obs() !== dc_t'(0)) begin
            miscompares++;
            $display("FAIL reset_regs: got %h expected %h", obs(), dc_t'(0));
        end
        vectors++;
        if (bus.out_stall_fe !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_stall: got %b expected 0", bus.out_stall_fe);
        end
        reset = 1'b0;
    endtask

    task automatic test_short();
        dc_t e;
        drive(16'h1234, 12'h010, 1'b0);
        vectors++;
        if ({bus.out_rf_addr1, bus.out_rf_addr2} !== 8'h34) begin
            miscompares++;
            $display("FAIL rf_addr_1234: got %h expected 34", {bus.out_rf_addr1, bus.out_rf_addr2});
        end
        tick();
        e = mk(1'b1, 16'h1234, 16'h0004, 12'h010);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL short_1234: got %h expected %h", obs(), e);
        end
        drive(16'h123C, 12'h012, 1'b0);
        tick();
        e = mk(1'b1, 16'h123C, 16'hFFFC, 12'h012);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL short_sext: got %h expected %h", obs(), e);
        end
        drive(16'h0000, 12'h014, 1'b0);
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL nop_valid: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_long();
        dc_t e;
        drive(16'h8120, 12'h020, 1'b0);
        tick();
        vectors++;
        if (obs() !== dc_t'(0)) begin
            miscompares++;
            $display("FAIL long_first_bubble: got %h expected %h", obs(), dc_t'(0));
        end
        drive(16'hBEEF, 12'h022, 1'b0);
        vectors++;
        if (bus.out_stall_fe !== 1'b0) begin
            miscompares++;
            $display("FAIL long_w1_stall: got %b expected 0", bus.out_stall_fe);
        end
        tick();
        e = mk(1'b1, 16'h8120, 16'hBEEF, 12'h020);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL long_emit: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_hazard();
        dc_t e;
        drive(16'h4500, 12'h030, 1'b0);
        tick();
        drive(16'h1056, 12'h032, 1'b0);
        vectors++;
        if (bus.out_stall_fe !== 1'b1) begin
            miscompares++;
            $display("FAIL hazard_stall: got %b expected 1", bus.out_stall_fe);
        end
        tick();
        vectors++;
        if (obs() !== dc_t'(0)) begin
            miscompares++;
            $display("FAIL hazard_bubble: got %h expected %h", obs(), dc_t'(0));
        end
        vectors++;
        if (bus.out_stall_fe !== 1'b0) begin
            miscompares++;
            $display("FAIL hazard_one_cycle: got %b expected 0", bus.out_stall_fe);
        end
        tick();
        e = mk(1'b1, 16'h1056, 16'h0006, 12'h032);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL hazard_resume: got %h expected %h", obs(), e);
        end
        drive(16'h4500, 12'h034, 1'b0);
        tick();
        drive(16'h1067, 12'h036, 1'b0);
        vectors++;
        if (bus.out_stall_fe !== 1'b0) begin
            miscompares++;
            $display("FAIL no_hazard_stall: got %b expected 0", bus.out_stall_fe);
        end
        tick();
        e = mk(1'b1, 16'h1067, 16'h0007, 12'h036);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL no_hazard_decode: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_flush();
        dc_t e;
        drive(16'h8120, 12'h040, 1'b0);
        tick();
        drive(16'hBEEF, 12'h042, 1'b1);
        tick();
        vectors++;
        if (obs() !== dc_t'(0)) begin
            miscompares++;
            $display("FAIL flush_w1_bubble: got %h expected %h", obs(), dc_t'(0));
        end
        drive(16'h1234, 12'h044, 1'b0);
        tick();
        e = mk(1'b1, 16'h1234, 16'h0004, 12'h044);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL flush_then_short: got %h expected %h", obs(), e);
        end
        drive(16'h4500, 12'h046, 1'b0);
        tick();
        drive(16'h1056, 12'h048, 1'b1);
        vectors++;
        if (bus.out_stall_fe !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_hazard_stall: got %b expected 0", bus.out_stall_fe);
        end
        tick();
        vectors++;
        if (obs() !== dc_t'(0)) begin
            miscompares++;
            $display("FAIL flush_hazard_bubble: got %h expected %h", obs(), dc_t'(0));
        end
        bus.in_flush = 1'b0;
    endtask

    task automatic test_reset_mid_long();
        dc_t e;
        drive(16'h8120, 12'h052, 1'b0);
        tick();
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (obs() !== dc_t'(0)) begin
            miscompares++;
            $display("FAIL reset_async: got %h expected %h", obs(), dc_t'(0));
        end
        tick();
        reset = 1'b0;
        drive(16'hBEEF, 12'h060, 1'b0);
        tick();
        vectors++;
        if (obs() !== dc_t'(0)) begin
            miscompares++;
            $display("FAIL reset_first_word: got %h expected %h", obs(), dc_t'(0));
        end
        drive(16'h0123, 12'h062, 1'b0);
        tick();
        e = mk(1'b1, 16'hBEEF, 16'h0123, 12'h060);
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL reset_long_emit: got %h expected %h", obs(), e);
        end
    endtask

    // Random word biased toward NOPs, LOADs, long ops and low register numbers
    function automatic logic [15:0] gen();
        logic [3:0]  op;
        logic [11:0] f;
        int          k;
        k = $urandom_range(0, 9);
        if ($urandom_range(0, 1) == 1)
            f = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
        else
            f = 12'($urandom);
        case (k)
            0:       return 16'h0000;
            1, 2:    op = 4'h4;
            3, 4:    op = 4'($urandom_range(8, 11));
            default: op = 4'($urandom);
        endcase
        return {op, f};
    endfunction

    task automatic test_random();
        dc_t         m_out;
        logic        m_pend;
        logic [15:0] m_hw;
        logic [11:0] m_hpc;
        logic [15:0] w;
        logic [11:0] pc;
        logic        fl;
        logic        hz;
        logic        exp_stall;
        logic        keep;
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        m_out  = '0;
        m_pend = 1'b0;
        m_hw   = '0;
        m_hpc  = '0;
        keep   = 1'b0;
        w      = '0;
        pc     = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!keep) begin
                w  = gen();
                pc = 12'($urandom);
            end
            fl = ($urandom_range(0, 15) == 0);
            drive(w, pc, fl);
            hz = !m_pend && m_out.valid && (m_out.op == 4'h4) && (w != 16'h0000)
              && ((m_out.rd == w[7:4]) || (m_out.rd == w[3:0]));
            exp_stall = hz && !fl;
            vectors++;
            if (bus.out_stall_fe !== exp_stall) begin
                miscompares++;
                $display("FAIL rand_stall[%0d]: got %b expected %b (word %h)", i, bus.out_stall_fe, exp_stall, w);
            end
            vectors++;
            if ({bus.out_rf_addr1, bus.out_rf_addr2} !== w[7:0]) begin
                miscompares++;
                $display("FAIL rand_rf_addr[%0d]: got %h expected %h", i, {bus.out_rf_addr1, bus.out_rf_addr2}, w[7:0]);
            end
            if (fl) begin
                m_out  = '0;
                m_pend = 1'b0;
            end else if (m_pend) begin
                m_out  = mk(1'b1, m_hw, w, m_hpc);
                m_pend = 1'b0;
            end else if (hz) begin
                m_out = '0;
            end else if (w[15:12] >= 4'h8 && w[15:12] <= 4'hB) begin
                m_hw   = w;
                m_hpc  = pc;
                m_pend = 1'b1;
                m_out  = '0;
            end else begin
                m_out = mk(w != 16'h0000, w, sext(w), pc);
            end
            tick();
            vectors++;
            if (obs() !== m_out) begin
                miscompares++;
                $display("FAIL rand_regs[%0d]: got %h expected %h (word %h)", i, obs(), m_out, w);
            end
            keep = exp_stall;
        end
    endtask

    initial begin
        bus.in_instr = '0;
        bus.in_pc    = '0;
        bus.in_flush = 1'b0;
        test_reset();
        test_short();
        test_long();
        test_hazard();
        test_flush();
        test_reset_mid_long();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
